// File: rtl/apb_slave_mem.sv
// APB slave with a small byte-wide memory.
// A Moore FSM (IDLE -> WAIT -> RESP) latches the setup-phase request, inserts
// WAIT_STATES access cycles with pready low, then completes in RESP.
// Out-of-range addresses complete with pslverr and never touch the memory.
module apb_slave_mem #(
  parameter int WAIT_STATES = 2,   // 0..15
  parameter int MEM_DEPTH   = 64   // 1..256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] pw_add,
  input  logic [7:0] pw_data,
  output logic [7:0] pr_data,
  output logic       pready,
  output logic       pslverr
);

  localparam int         AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // Counter preload: the first WAIT cycle already counts as one wait state.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [7:0]  addr_q,  addr_d;
  logic [7:0]  data_q,  data_d;
  logic        wr_q,    wr_d;
  logic [7:0]  mem_q [MEM_DEPTH];

  logic          setup;
  logic          in_range;
  logic          in_resp;
  logic          mem_we;
  logic [AW-1:0] mem_idx;

  assign setup    = psel & ~penable;
  assign in_range = ({1'b0, addr_q} < 9'(MEM_DEPTH));
  assign in_resp  = (state_q == RESP);
  assign mem_idx  = addr_q[AW-1:0];
  // The write commits on the edge that ends RESP, using only latched values.
  assign mem_we   = in_resp & wr_q & in_range;

  // Next-state logic and request latching.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        // penable without a preceding setup phase is ignored here.
        if (setup) begin
          addr_d = pw_add;
          data_d = pw_data;
          wr_d   = pwrite;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          // Master abandoned the transfer: no response, no memory update.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Moore outputs: everything is quiet outside RESP.
  always_comb begin
    pready  = in_resp;
    pslverr = in_resp & ~in_range;
    pr_data = 8'h00;
    if (in_resp && in_range && !wr_q) begin
      pr_data = mem_q[mem_idx];
    end
  end

  // FSM state, wait counter and latched request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
    end
  end

  // Storage array; reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (mem_we) begin
      mem_q[mem_idx] <= data_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (WAIT_STATES=2 and 0, MEM_DEPTH=64)
// driven independently and checked against an array-based memory model.
module tb_apb_slave_mem;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     [2];
  logic       psel    [2];
  logic       penable [2];
  logic       pwrite  [2];
  logic [7:0] paddr   [2];
  logic [7:0] pwdata  [2];
  logic [7:0] prdata  [2];
  logic       pready  [2];
  logic       pslverr [2];

  apb_slave_mem #(.WAIT_STATES(2), .MEM_DEPTH(DEPTH)) u_ws2 (
    .clk(clk), .rst(rst[0]), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .pw_add(paddr[0]), .pw_data(pwdata[0]),
    .pr_data(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
  );

  apb_slave_mem #(.WAIT_STATES(0), .MEM_DEPTH(DEPTH)) u_ws0 (
    .clk(clk), .rst(rst[1]), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .pw_add(paddr[1]), .pw_data(pwdata[1]),
    .pr_data(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
  );

  int         ws [2];
  logic [7:0] mdl [2][DEPTH];
  int         nchk  = 0;
  int         nfail = 0;

  // Reference: a plain byte array; out-of-range accesses error and do nothing.
  function automatic void model(input int d, input bit wr, input logic [7:0] a,
                                input logic [7:0] wd, output logic [7:0] erd,
                                output logic eer);
    eer = (int'(a) >= DEPTH);
    erd = 8'h00;
    if (!eer) begin
      if (wr) mdl[d][int'(a)] = wd;
      else    erd = mdl[d][int'(a)];
    end
  endfunction

  function automatic void model_clear(input int d);
    for (int i = 0; i < DEPTH; i++) mdl[d][i] = 8'h00;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the completing edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One APB transfer. lat = cycles from setup to pready (0 = timed out);
  // quiet = outputs stayed all-zero while pready was low.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                      input logic [7:0] wd, input bit mut, input bit m_w,
                      input logic [7:0] m_a, input logic [7:0] m_d,
                      output logic [7:0] rd, output logic er,
                      output int lat, output bit quiet);
    psel[d] = 1'b1; penable[d] = 1'b0;
    pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    quiet = 1'b1; lat = 0; rd = 8'h00; er = 1'b0;
    @(negedge clk);
    if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 8'h00) quiet = 1'b0;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    if (mut) begin
      pwrite[d] = m_w; paddr[d] = m_a; pwdata[d] = m_d;
    end
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (pready[d] === 1'b1) begin
        lat = k; rd = prdata[d]; er = pslverr[d];
      end else if (pslverr[d] !== 1'b0 || prdata[d] !== 8'h00) begin
        quiet = 1'b0;
      end
      @(posedge clk); #1;
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd; logic er; int lat; bit q;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1;
      paddr[d] = 8'h00; pwdata[d] = 8'hEE;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if ({pready[d], pslverr[d], prdata[d]} !== 10'b0) begin
        nfail++;
        $display("FAIL reset_outputs dut%0d got=%b exp=0", d, {pready[d], pslverr[d], prdata[d]});
      end
      model_clear(d);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    // First setup right after release must be accepted.
    xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, rd, er, lat, q);
    nchk++;
    if (lat !== 1 + ws[0]) begin
      nfail++; $display("FAIL reset_first_setup got_lat=%0d exp=%0d", lat, 1 + ws[0]);
    end
    nchk++;
    if (rd !== 8'h00) begin
      nfail++; $display("FAIL reset_mem_zero got=%h exp=00", rd);
    end
  endtask

  task automatic test_basic_ws2();
    logic [7:0] rd, erd; logic er, eer; int lat; bit q;
    xfer(0, 1'b1, 8'h05, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, rd, er, lat, q);
    model(0, 1'b1, 8'h05, 8'h3C, erd, eer);
    nchk++;
    if (lat !== 3) begin nfail++; $display("FAIL ws2_write_lat got=%0d exp=3", lat); end
    nchk++;
    if (er !== 1'b0) begin nfail++; $display("FAIL ws2_write_err got=%b exp=0", er); end
    nchk++;
    if (q !== 1'b1) begin nfail++; $display("FAIL ws2_write_quiet got=%b exp=1", q); end
    idle(2);
    xfer(0, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, rd, er, lat, q);
    model(0, 1'b0, 8'h05, 8'h00, erd, eer);
    nchk++;
    if (rd !== erd || lat !== 3) begin
      nfail++; $display("FAIL ws2_read got=%h/lat%0d exp=%h/lat3", rd, lat, erd);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd, erd; logic er, eer; int lat; bit q;
    for (int d = 0; d < 2; d++) begin
      xfer(d, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, rd, er, lat, q);
      model(d, 1'b1, 8'h10, 8'hA5, erd, eer);
      nchk++;
      if (lat !== 1 + ws[d]) begin
        nfail++; $display("FAIL b2b_write_lat dut%0d got=%0d exp=%0d", d, lat, 1 + ws[d]);
      end
      xfer(d, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, rd, er, lat, q);
      model(d, 1'b0, 8'h10, 8'h00, erd, eer);
      nchk++;
      if (rd !== erd || lat !== 1 + ws[d] || er !== 1'b0) begin
        nfail++; $display("FAIL b2b_read dut%0d got=%h/lat%0d/err%b exp=%h/lat%0d/err0",
                          d, rd, lat, er, erd, 1 + ws[d]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rd; logic er; int lat; bit q;
    xfer(0, 1'b1, 8'h40, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, rd, er, lat, q);
    nchk++;
    if (er !== 1'b1 || lat !== 3) begin
      nfail++; $display("FAIL oor_write got=err%b/lat%0d exp=err1/lat3", er, lat);
    end
    xfer(0, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, rd, er, lat, q);
    nchk++;
    if (er !== 1'b1 || rd !== 8'h00) begin
      nfail++; $display("FAIL oor_read got=err%b/%h exp=err1/00", er, rd);
    end
    // Write to 0x40 must not alias onto address 0x00.
    xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, rd, er, lat, q);
    nchk++;
    if (rd !== mdl[0][0] || er !== 1'b0) begin
      nfail++; $display("FAIL oor_alias got=%h/err%b exp=%h/err0", rd, er, mdl[0][0]);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rd, erd; logic er, eer; int lat; bit q; bit seen;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 8'h02; pwdata[0] = 8'h77;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (pready[0] !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    nchk++;
    if (seen !== 1'b0) begin nfail++; $display("FAIL abort_no_pready got=1 exp=0"); end
    xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, rd, er, lat, q);
    model(0, 1'b0, 8'h02, 8'h00, erd, eer);
    nchk++;
    if (rd !== erd || lat !== 3) begin
      nfail++; $display("FAIL abort_read got=%h/lat%0d exp=%h/lat3", rd, lat, erd);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [7:0] rd, erd; logic er, eer; int lat; bit q;
    xfer(0, 1'b1, 8'h01, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, rd, er, lat, q);
    model(0, 1'b1, 8'h01, 8'h5A, erd, eer);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 8'h01; pwdata[0] = 8'h66;
    @(posedge clk); #1;
    penable[0] = 1'b1; rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
    model_clear(0);
    @(negedge clk);
    nchk++;
    if ({pready[0], pslverr[0], prdata[0]} !== 10'b0) begin
      nfail++; $display("FAIL rst_wait_outputs got=%b exp=0", {pready[0], pslverr[0], prdata[0]});
    end
    @(posedge clk); #1;
    xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, rd, er, lat, q);
    nchk++;
    if (rd !== 8'h00 || lat !== 3) begin
      nfail++; $display("FAIL rst_wait_read got=%h/lat%0d exp=00/lat3", rd, lat);
    end
  endtask

  task automatic test_addr_change();
    logic [7:0] rd, erd; logic er, eer; int lat; bit q;
    xfer(0, 1'b1, 8'h03, 8'h11, 1'b1, 1'b1, 8'h04, 8'h99, rd, er, lat, q);
    model(0, 1'b1, 8'h03, 8'h11, erd, eer);
    xfer(0, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, rd, er, lat, q);
    nchk++;
    if (rd !== 8'h11) begin nfail++; $display("FAIL addr_chg_0x03 got=%h exp=11", rd); end
    xfer(0, 1'b0, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, rd, er, lat, q);
    model(0, 1'b0, 8'h04, 8'h00, erd, eer);
    nchk++;
    if (rd !== erd) begin nfail++; $display("FAIL addr_chg_0x04 got=%h exp=%h", rd, erd); end
  endtask

  task automatic test_random();
    logic [7:0] rd, erd, a, wd; logic er, eer; int lat; bit q, wr, mut;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 80; n++) begin
        wr  = 1'($urandom_range(0, 1));
        a   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(DEPTH, 255))
                                          : 8'($urandom_range(0, DEPTH - 1));
        wd  = 8'($urandom);
        mut = 1'($urandom_range(0, 1));
        xfer(d, wr, a, wd, mut, 1'($urandom), 8'($urandom), 8'($urandom), rd, er, lat, q);
        model(d, wr, a, wd, erd, eer);
        nchk++;
        if (lat !== 1 + ws[d] || er !== eer || q !== 1'b1) begin
          nfail++;
          $display("FAIL rand_resp dut%0d n=%0d got=lat%0d/err%b/quiet%b exp=lat%0d/err%b/quiet1",
                   d, n, lat, er, q, 1 + ws[d], eer);
        end
        if (!wr) begin
          nchk++;
          if (rd !== erd) begin
            nfail++; $display("FAIL rand_read dut%0d n=%0d a=%h got=%h exp=%h", d, n, a, rd, erd);
          end
        end
        idle($urandom_range(0, 2));
      end
    end
  endtask

  initial begin
    ws[0] = 2; ws[1] = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = 8'h00; pwdata[d] = 8'h00;
      model_clear(d);
    end
    test_reset();
    test_basic_ws2();
    test_back_to_back();
    test_out_of_range();
    test_abort();
    test_reset_in_wait();
    test_addr_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2: number of access-phase cycles with pready low before pready rises (0..15).
REQ-002 SHALL have parameter MEM_DEPTH, default 64: number of 8-bit storage locations (1..256); addresses at or above it are out of range.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port psel, input, 1 bit: slave select from the APB master.
REQ-006 SHALL have port penable, input, 1 bit: access-phase indicator from the master.
REQ-007 SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port pw_add, input, 8 bits: transfer address.
REQ-009 SHALL have port pw_data, input, 8 bits: write data.
REQ-010 SHALL have port pr_data, output, 8 bits: read data returned to the master.
REQ-011 SHALL have port pready, output, 1 bit: transfer-complete strobe.
REQ-012 SHALL have port pslverr, output, 1 bit: transfer error, valid only while pready=1.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, WAIT and RESP, held in registers.
REQ-014 IDLE: a setup phase (psel=1, penable=0) SHALL latch pw_add, pwrite and pw_data into internal registers.
REQ-015 IDLE, on that setup phase: next state SHALL be RESP if WAIT_STATES=0, else WAIT with the wait counter loaded to WAIT_STATES-1.
REQ-016 IDLE SHALL ignore penable=1 without a preceding setup phase and remain in IDLE.
REQ-017 WAIT: if psel=0 (abort), SHALL go to IDLE with no memory update.
REQ-018 WAIT: if the counter is 0, SHALL go to RESP; otherwise SHALL decrement the counter by 1 and stay in WAIT.
REQ-019 RESP SHALL last exactly one cycle, then go to IDLE; a back-to-back setup phase on the next cycle is accepted from IDLE per REQ-014.
REQ-020 pready SHALL be 1 only in RESP; with setup in cycle T0, pready SHALL be high in cycle T0+1+WAIT_STATES.
REQ-021 Write (latched pwrite=1, address in range): memory SHALL update at the clock edge ending RESP, from the latched data.
REQ-022 Read (latched pwrite=0, address in range): pr_data SHALL equal mem[latched address] during RESP.
REQ-023 pr_data SHALL be 8'h00 in every state other than RESP.
REQ-024 Latched address >= MEM_DEPTH: pslverr SHALL be 1 during RESP, the write SHALL be suppressed, and pr_data SHALL be 8'h00.
REQ-025 pslverr SHALL be 0 outside RESP.
REQ-026 Changes on pw_add, pw_data or pwrite after the setup phase SHALL NOT affect the current transfer.
REQ-027 A read of a location written in the immediately preceding transfer SHALL return the new value.

Reset
REQ-028 rst=1 SHALL force state IDLE, wait counter 0, latched registers 0, pready=0, pslverr=0, pr_data=8'h00, and all memory locations 8'h00, at the next rising clk edge.
REQ-029 rst asserted in WAIT or RESP SHALL abort the transfer, and no memory write SHALL occur on that edge.
REQ-030 The first setup phase SHALL be recognised on the first cycle after rst deasserts.

Verification
REQ-031 Bench SHALL cover, with WAIT_STATES=2: write 0x3C to address 0x05 (setup T0) -> pready=1 only in T3, pslverr=0; later read of 0x05 -> pr_data=0x3C with pready.
REQ-032 Bench SHALL cover, with WAIT_STATES=0: setup in T0 -> pready=1 in T1; back-to-back write then read of address 0x10, data 0xA5 -> read returns 0xA5 with no idle cycle between transfers.
REQ-033 Bench SHALL cover, with MEM_DEPTH=64: write 0xFF to address 0x40 -> pslverr=1 with pready; subsequent read of 0x40 -> pslverr=1, pr_data=0x00.
REQ-034 Bench SHALL cover: psel dropped in WAIT during a write of 0x77 to address 0x02 -> FSM returns to IDLE, no pready pulse, and a later read of 0x02 returns 0x00.
REQ-035 Bench SHALL cover: rst asserted in WAIT of a write to address 0x01 -> all outputs 0 next cycle; a read of 0x01 after release returns 0x00.
REQ-036 Bench SHALL cover: pw_add changed from 0x03 to 0x04 during the access phase of a write of 0x11 -> only address 0x03 holds 0x11.
